// File: rtl/eth_pcs_params.sv
// Shared 10GBASE-R PCS constants, header helpers and
// block-sync FSM state encoding.
package eth_pcs_params;

  localparam int W_SYNC    = 2;
  localparam int W_PLD_BLK = 64;

  localparam int SH_VAL_TH   = 64;
  localparam int SH_INVAL_TH = 16;

  localparam int W_SH_VAL_TH   = $clog2(SH_VAL_TH) + 1;
  localparam int W_SH_INVAL_TH = $clog2(SH_INVAL_TH) + 1;

  localparam int SLIP_HOLDOFF_DEF = 4;
  localparam int W_HOLDOFF        = 4;

  localparam logic [W_SYNC-1:0] SYNC_DATA = 2'b01;
  localparam logic [W_SYNC-1:0] SYNC_CTRL = 2'b10;

  typedef enum logic [1:0] {
    RESET_CNT,
    TEST_SH,
    SLIP,
    SLIP_WAIT
  } blk_sync_state_t;

  function automatic logic is_sync_hdr_valid(
    input logic [W_SYNC-1:0] hdr
  );
    return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/eth_pcs_rx_block_sync.sv
// 10GBASE-R RX block lock: sync-header hunt, gearbox
// slip requests and one-cycle forwarding of locked blocks.
module eth_pcs_rx_block_sync
  import eth_pcs_params::*;
#(
  parameter int SLIP_HOLDOFF = SLIP_HOLDOFF_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_signal_ok,
  input  logic                 i_blk_valid,
  input  logic [W_SYNC-1:0]    i_sync_hdr,
  input  logic [W_PLD_BLK-1:0] i_blk_data,
  output logic                 o_slip,
  output logic                 o_block_lock,
  output logic                 o_blk_valid,
  output logic [W_SYNC-1:0]    o_sync_hdr,
  output logic [W_PLD_BLK-1:0] o_blk_data
);

  localparam int WV = W_SH_VAL_TH;
  localparam int WI = W_SH_INVAL_TH;
  localparam int WH = W_HOLDOFF;

  localparam logic [WV-1:0] VAL_TH = WV'(SH_VAL_TH);
  localparam logic [WI-1:0] INV_TH = WI'(SH_INVAL_TH);
  localparam logic [WH-1:0] HOLD   = WH'(SLIP_HOLDOFF);
  localparam logic [WV-1:0] ONE_V  = WV'(1);
  localparam logic [WH-1:0] ONE_H  = WH'(1);

  blk_sync_state_t state;

  logic [WV-1:0] sh_cnt;
  logic [WI-1:0] inv_cnt;
  logic [WH-1:0] hold_cnt;

  logic          hdr_bad;
  logic [WV-1:0] c_nxt;
  logic [WI-1:0] v_nxt;
  logic          go_slip;
  logic          win_done;
  logic          testing;
  logic          lock_now;

  // Decision uses post-increment counts so the
  // deciding header acts in its own cycle.
  always_comb begin
    hdr_bad  = !is_sync_hdr_valid(i_sync_hdr);
    c_nxt    = sh_cnt + ONE_V;
    v_nxt    = inv_cnt + WI'(hdr_bad);
    go_slip  = (hdr_bad && !o_block_lock) ||
               (v_nxt == INV_TH);
    win_done = (c_nxt == VAL_TH);
    testing  = i_signal_ok && i_blk_valid &&
               (state == TEST_SH);
    lock_now = o_block_lock;
    if (!i_signal_ok) begin
      lock_now = 1'b0;
    end else if (testing) begin
      if (go_slip) begin
        lock_now = 1'b0;
      end else if (win_done && (v_nxt == '0)) begin
        lock_now = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RESET_CNT;
      sh_cnt       <= '0;
      inv_cnt      <= '0;
      hold_cnt     <= '0;
      o_slip       <= 1'b0;
      o_block_lock <= 1'b0;
      o_blk_valid  <= 1'b0;
      o_sync_hdr   <= '0;
      o_blk_data   <= '0;
    end else begin
      o_slip       <= 1'b0;
      o_block_lock <= lock_now;
      o_blk_valid  <= i_blk_valid & lock_now;
      if (i_blk_valid) begin
        o_sync_hdr <= i_sync_hdr;
        o_blk_data <= i_blk_data;
      end
      if (!i_signal_ok) begin
        state    <= RESET_CNT;
        sh_cnt   <= '0;
        inv_cnt  <= '0;
        hold_cnt <= '0;
      end else begin
        unique case (state)
          RESET_CNT: begin
            sh_cnt  <= '0;
            inv_cnt <= '0;
            state   <= TEST_SH;
          end
          TEST_SH: begin
            if (i_blk_valid) begin
              if (go_slip) begin
                o_slip  <= 1'b1;
                sh_cnt  <= '0;
                inv_cnt <= '0;
                state   <= SLIP;
              end else if (win_done) begin
                sh_cnt  <= '0;
                inv_cnt <= '0;
              end else begin
                sh_cnt  <= c_nxt;
                inv_cnt <= v_nxt;
              end
            end
          end
          SLIP: begin
            sh_cnt   <= '0;
            inv_cnt  <= '0;
            hold_cnt <= HOLD;
            state    <= SLIP_WAIT;
          end
          SLIP_WAIT: begin
            if (i_blk_valid) begin
              hold_cnt <= hold_cnt - ONE_H;
              if (hold_cnt <= ONE_H) begin
                state <= TEST_SH;
              end
            end
          end
          default: state <= RESET_CNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eth_pcs_rx_block_sync.sv
// Directed vector bench for the RX block-lock stage.
module tb_eth_pcs_rx_block_sync;

  logic        clk = 1'b0;
  logic        rst;
  logic        sig_ok;
  logic        blk_valid;
  logic [1:0]  sync_hdr;
  logic [63:0] blk_data;
  logic        slip;
  logic        block_lock;
  logic        out_valid;
  logic [1:0]  out_hdr;
  logic [63:0] out_data;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  eth_pcs_rx_block_sync dut (
    .clk         (clk),
    .rst         (rst),
    .i_signal_ok (sig_ok),
    .i_blk_valid (blk_valid),
    .i_sync_hdr  (sync_hdr),
    .i_blk_data  (blk_data),
    .o_slip      (slip),
    .o_block_lock(block_lock),
    .o_blk_valid (out_valid),
    .o_sync_hdr  (out_hdr),
    .o_blk_data  (out_data)
  );

  typedef struct {
    logic        ok;
    logic        vld;
    logic [1:0]  hdr;
    logic [63:0] data;
    logic        e_lock;
    logic        e_slip;
    logic        e_vld;
  } vec_t;

  vec_t vec[$];

  task automatic add(
    input logic ok, input logic vld,
    input logic [1:0] hdr, input logic e_lock,
    input logic e_slip, input logic e_vld
  );
    vec_t v;
    int   n;
    n        = vec.size();
    v.ok     = ok;
    v.vld    = vld;
    v.hdr    = hdr;
    v.data   = {32'(n) ^ 32'hC0DE_5A00,
                32'(n) * 32'h9E37_79B9};
    v.e_lock = e_lock;
    v.e_slip = e_slip;
    v.e_vld  = e_vld;
    vec.push_back(v);
  endtask

  // n good blocks, expecting lock on the last one
  task automatic add_relock();
    for (int i = 0; i < 63; i++) add(1, 1, 2'b01, 0, 0, 0);
    add(1, 1, 2'b10, 1, 0, 1);
  endtask

  task automatic chk(
    input string name, input int step,
    input logic [63:0] act, input logic [63:0] exp
  );
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s step %0d: got %h want %h",
                  name, step, act, exp);
  endtask

  initial begin
    rst       = 1'b1;
    sig_ok    = 1'b1;
    blk_valid = 1'b0;
    sync_hdr  = 2'b00;
    blk_data  = '0;

    // acquisition
    add(1, 0, 2'b01, 0, 0, 0);
    add_relock();
    // tolerated: 15 errors, clean window, 15 errors
    for (int i = 0; i < 64; i++)
      add(1, 1, (i % 4 == 0 && i < 60) ?
          ((i % 8 == 0) ? 2'b00 : 2'b11) : 2'b01,
          1, 0, 1);
    for (int i = 0; i < 64; i++) add(1, 1, 2'b10, 1, 0, 1);
    for (int i = 0; i < 64; i++)
      add(1, 1, (i >= 49) ? 2'b11 : 2'b01, 1, 0, 1);
    // loss of lock: 16th bad header
    for (int i = 0; i < 15; i++) add(1, 1, 2'b00, 1, 0, 1);
    add(1, 1, 2'b00, 0, 1, 0);
    add(1, 1, 2'b11, 0, 0, 0);
    add(1, 1, 2'b11, 0, 0, 0);
    add(1, 1, 2'b11, 0, 0, 0);
    add(1, 0, 2'b11, 0, 0, 0);
    add(1, 1, 2'b11, 0, 0, 0);
    add(1, 1, 2'b11, 0, 0, 0);
    // unlocked slip
    add(1, 1, 2'b01, 0, 0, 0);
    add(1, 1, 2'b01, 0, 0, 0);
    add(1, 1, 2'b11, 0, 1, 0);
    for (int i = 0; i < 5; i++) add(1, 1, 2'b00, 0, 0, 0);
    add_relock();
    // signal loss mid-window
    for (int i = 0; i < 30; i++) add(1, 1, 2'b01, 1, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 1, 2'b01, 0, 0, 0);
    add(1, 0, 2'b01, 0, 0, 0);
    add_relock();
    // signal loss cancels a pending slip
    add(0, 0, 2'b01, 0, 0, 0);
    add(1, 0, 2'b01, 0, 0, 0);
    add(1, 1, 2'b11, 0, 1, 0);
    add(0, 1, 2'b01, 0, 0, 0);
    add(1, 0, 2'b01, 0, 0, 0);
    add_relock();
    // park in SLIP_WAIT for the async reset check
    for (int i = 0; i < 15; i++) add(1, 1, 2'b11, 1, 0, 1);
    add(1, 1, 2'b11, 0, 1, 0);
    add(1, 1, 2'b11, 0, 0, 0);
    add(1, 1, 2'b11, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_lock", -1, 64'(block_lock), 0);
    chk("rst_slip", -1, 64'(slip), 0);
    chk("rst_vld", -1, 64'(out_valid), 0);
    chk("rst_hdr", -1, 64'(out_hdr), 0);
    chk("rst_data", -1, out_data, 0);
    #2 rst = 1'b0;

    for (int i = 0; i < vec.size(); i++) begin
      sig_ok    = vec[i].ok;
      blk_valid = vec[i].vld;
      sync_hdr  = vec[i].hdr;
      blk_data  = vec[i].data;
      @(posedge clk);
      #1;
      chk("lock", i, 64'(block_lock), 64'(vec[i].e_lock));
      chk("slip", i, 64'(slip), 64'(vec[i].e_slip));
      chk("vld", i, 64'(out_valid), 64'(vec[i].e_vld));
      if (vec[i].vld) begin
        chk("hdr", i, 64'(out_hdr), 64'(vec[i].hdr));
        chk("data", i, out_data, vec[i].data);
      end
    end

    // async reset while in SLIP_WAIT
    #3 rst = 1'b1;
    #1;
    chk("arst_lock", -2, 64'(block_lock), 0);
    chk("arst_slip", -2, 64'(slip), 0);
    chk("arst_vld", -2, 64'(out_valid), 0);
    chk("arst_hdr", -2, 64'(out_hdr), 0);
    chk("arst_data", -2, out_data, 0);
    blk_valid = 1'b0;
    repeat (2) @(posedge clk);
    #4 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      blk_valid = (i > 0);
      sync_hdr  = 2'b01;
      @(posedge clk);
      #1;
      chk("post_slip", -3, 64'(slip), 0);
      chk("post_lock", -3, 64'(block_lock), 0);
      chk("post_vld", -3, 64'(out_valid), 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
